// File: rtl/idu_pipe_if.sv
// Fetch-side and decode-side handshake bundle for idu_pipe.
// master drives the fetch offer and downstream ready; slave is the buffer.
interface idu_pipe_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc
  );
endinterface

// File: rtl/idu_pipe.sv
// Instruction buffer with combinational RV32I decode of the head entry.
// Define IDU_RV32M_EN to accept the M-extension OP encodings (f7 = 0x01).
module idu_pipe #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  idu_pipe_if.slave   bus,
  input  logic        flush,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [9:0]  funcEU,
  output logic [1:0]  amux1,
  output logic [1:0]  amux2,
  output logic        wen,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [7:0]  wmask,
  output logic        illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [31:0]     inst_q [DEPTH];
  logic [PC_W-1:0] pc_q   [DEPTH];

  logic push;
  logic pop;

  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= bus.in_inst;
      pc_q[wr_ptr]   <= bus.in_pc;
    end
  end

  logic [31:0] hi;
  logic [6:0]  f7;
  logic        f7_ok;

  assign hi = inst_q[rd_ptr];
  assign f7 = hi[31:25];
  assign bus.out_pc = bus.out_valid ? pc_q[rd_ptr] : '0;

`ifdef IDU_RV32M_EN
  assign f7_ok = (f7 == 7'h00) || (f7 == 7'h20) || (f7 == 7'h01);
`else
  assign f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
`endif

  always_comb begin
    rs1       = '0;
    rs2       = '0;
    rd        = '0;
    imm       = '0;
    opcode    = '0;
    func3     = '0;
    funcEU    = '0;
    amux1     = '0;
    amux2     = '0;
    wen       = 1'b0;
    mem_valid = 1'b0;
    mem_wen   = 1'b0;
    wmask     = '0;
    illegal   = 1'b0;
    if (bus.out_valid) begin
      rs1    = hi[19:15];
      rs2    = hi[24:20];
      rd     = hi[11:7];
      func3  = hi[14:12];
      opcode = hi[6:0];
      case (hi[6:0])
        OP_LUI: begin
          imm   = {hi[31:12], 12'b0};
          amux2 = 2'd2;
          wen   = 1'b1;
        end
        OP_AUIPC: begin
          imm   = {hi[31:12], 12'b0};
          amux1 = 2'd2;
          amux2 = 2'd2;
          wen   = 1'b1;
        end
        OP_JAL: begin
          imm   = {{11{hi[31]}}, hi[31], hi[19:12],
                   hi[20], hi[30:21], 1'b0};
          amux1 = 2'd2;
          amux2 = 2'd2;
          wen   = 1'b1;
        end
        OP_JALR: begin
          imm   = {{20{hi[31]}}, hi[31:20]};
          amux1 = 2'd1;
          amux2 = 2'd2;
          wen   = 1'b1;
        end
        OP_BRANCH: begin
          imm   = {{19{hi[31]}}, hi[31], hi[7],
                   hi[30:25], hi[11:8], 1'b0};
          amux1 = 2'd1;
          amux2 = 2'd1;
        end
        OP_LOAD: begin
          imm       = {{20{hi[31]}}, hi[31:20]};
          amux1     = 2'd1;
          amux2     = 2'd2;
          wen       = 1'b1;
          mem_valid = 1'b1;
        end
        OP_STORE: begin
          imm       = {{20{hi[31]}}, hi[31:25], hi[11:7]};
          amux1     = 2'd1;
          amux2     = 2'd2;
          mem_valid = 1'b1;
          mem_wen   = 1'b1;
          case (hi[14:12])
            3'd0:    wmask = 8'h01;
            3'd1:    wmask = 8'h03;
            3'd2:    wmask = 8'h0F;
            default: wmask = 8'h00;
          endcase
          illegal = (hi[14:12] > 3'd2);
        end
        OP_IMM: begin
          imm   = {{20{hi[31]}}, hi[31:20]};
          amux1 = 2'd1;
          amux2 = 2'd2;
          wen   = 1'b1;
          // Only the shift-immediates carry a real f7.
          if (hi[14:12] == 3'd1 || hi[14:12] == 3'd5)
            funcEU = {hi[14:12], f7};
          else
            funcEU = {hi[14:12], 7'b0};
        end
        OP_OP: begin
          funcEU  = {hi[14:12], f7};
          amux1   = 2'd1;
          amux2   = 2'd1;
          wen     = 1'b1;
          illegal = !f7_ok;
        end
        OP_SYSTEM: begin
        end
        default: illegal = 1'b1;
      endcase
      if (illegal) begin
        wen       = 1'b0;
        mem_valid = 1'b0;
        mem_wen   = 1'b0;
      end
    end
  end

endmodule
